// File: rtl/disp_pkg.sv
// Shared types and seven-segment constants for the number display path.
package disp_pkg;

    typedef enum logic {IDLE, SHIFT} disp_state_t;

    // Active-high segments: bit0=a .. bit6=g, bit7=dp (always off).
    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam int unsigned MAX_DISPLAY = 9999;

endpackage

// File: rtl/bcd_to_seg.sv
// One BCD digit plus blank request to seven-segment pattern.
module bcd_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // Non-decimal codes cannot come out of the converter; show a dash if they ever do.
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (bcd_i <= 4'd9) begin
            seg_o = SEG_DIGIT[bcd_i];
        end
    end

endmodule

// File: rtl/number_display.sv
// Sequential double-dabble binary-to-BCD converter driving four seven-segment digits.
module number_display
    import disp_pkg::*;
#(
    parameter int unsigned WIDTH         = 14,
    parameter int unsigned DIGITS        = 4,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7:0]            ss3,
    output logic [7:0]            ss2,
    output logic [7:0]            ss1,
    output logic [7:0]            ss0
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned SW = 4 * DIGITS;
    localparam logic [7:0]  SS_HI_RST = BLANK_LEADING ? SEG_BLANK : SEG_DIGIT[0];

    disp_state_t              state_q;
    logic [CW-1:0]            count_q;
    logic [WIDTH-1:0]         shift_q;
    logic [SW-1:0]            scratch_q;
    logic                     ovf_pend_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     ovf_q;
    logic [SW-1:0]            bcd_q;
    logic [DIGITS-1:0][7:0]   ss_q;

    logic [SW-1:0]            adj;
    logic [SW-1:0]            scratch_nxt;
    logic [WIDTH-1:0]         shift_nxt;
    logic [CW-1:0]            count_nxt;
    logic [DIGITS-1:0]        blank;
    logic                     lead_zero;
    logic [DIGITS-1:0][7:0]   seg_nxt;
    logic                     value_ovf;
    logic                     unused_adj_msb;

    assign value_ovf = (32'(value) > MAX_DISPLAY);

    // Add-3 correction then one-bit left shift of {scratch, shift}; scratch MSB falls off.
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end
        end
        scratch_nxt = {adj[SW-2:0], shift_q[WIDTH-1]};
        shift_nxt   = {shift_q[WIDTH-2:0], 1'b0};
        count_nxt   = count_q + CW'(1);
    end

    assign unused_adj_msb = adj[SW-1];

    // A digit blanks when it and every digit above it are zero; the units digit never blanks.
    always_comb begin
        lead_zero = 1'b1;
        blank     = '0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            lead_zero = lead_zero & (scratch_nxt[4*k +: 4] == 4'd0);
            blank[k]  = BLANK_LEADING & lead_zero;
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_seg
        bcd_to_seg u_seg (
            .bcd_i   (scratch_nxt[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (seg_nxt[g])
        );
    end

    // Conversion FSM; visible outputs update only on the final shift edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd_q      <= '0;
            ss_q[0]    <= SEG_DIGIT[0];
            for (int k = 1; k < int'(DIGITS); k++) begin
                ss_q[k] <= SS_HI_RST;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q    <= value;
                        scratch_q  <= '0;
                        count_q    <= '0;
                        ovf_pend_q <= value_ovf;
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= scratch_nxt;
                    shift_q   <= shift_nxt;
                    count_q   <= count_nxt;
                    if (count_nxt == CW'(WIDTH)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ovf_q   <= ovf_pend_q;
                        bcd_q   <= ovf_pend_q ? '0 : scratch_nxt;
                        for (int k = 0; k < int'(DIGITS); k++) begin
                            ss_q[k] <= ovf_pend_q ? SEG_DASH : seg_nxt[k];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd  = bcd_q;
    assign ss3  = ss_q[3];
    assign ss2  = ss_q[2];
    assign ss1  = ss_q[1];
    assign ss0  = ss_q[0];

endmodule

// File: tb/tb_number_display.sv
// Self-checking bench: decimal-arithmetic reference model compared every cycle, plus directed literals.
module tb_number_display;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] value = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd;
    logic [7:0]  ss3, ss2, ss1, ss0;

    int checks = 0;
    int errors = 0;

    number_display #(
        .WIDTH         (14),
        .DIGITS        (4),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd   (bcd),
        .ss3   (ss3),
        .ss2   (ss2),
        .ss1   (ss1),
        .ss0   (ss0)
    );

    always #5 clk = ~clk;

    logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Reference model state
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic       m_ovf  = 1'b0;
    logic [15:0] m_bcd = '0;
    logic [7:0] m_ss [4] = '{8'h3F, 8'h00, 8'h00, 8'h00};
    int         m_left = 0;
    int         m_val  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of converting v, from decimal arithmetic.
    task automatic publish(input int v);
        int d [4];
        int p;
        if (v > 9999) begin
            m_ovf = 1'b1;
            m_bcd = '0;
            for (int k = 0; k < 4; k++) m_ss[k] = 8'h40;
        end else begin
            m_ovf = 1'b0;
            d[0] = v % 10;
            d[1] = (v / 10) % 10;
            d[2] = (v / 100) % 10;
            d[3] = v / 1000;
            m_bcd = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
            p = 1;
            for (int k = 0; k < 4; k++) begin
                m_ss[k] = (k > 0 && v < p) ? 8'h00 : seg_tab[d[k]];
                p = p * 10;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ovf  = 1'b0;
            m_bcd  = '0;
            m_ss[0] = 8'h3F;
            m_ss[1] = 8'h00;
            m_ss[2] = 8'h00;
            m_ss[3] = 8'h00;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    publish(m_val);
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = 14;
                m_val  = int'(value);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("ovf",  32'(ovf),  32'(m_ovf));
        chk("bcd",  32'(bcd),  32'(m_bcd));
        chk("ss3",  32'(ss3),  32'(m_ss[3]));
        chk("ss2",  32'(ss2),  32'(m_ss[2]));
        chk("ss1",  32'(ss1),  32'(m_ss[1]));
        chk("ss0",  32'(ss0),  32'(m_ss[0]));
    end

    // Waits for done after the start edge; lat = edges from start edge to done (0 on timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic convert(input int v, output int lat);
        @(posedge clk);
        #2 value = 14'(v);
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(lat);
    endtask

    task automatic chk_lit(input string name, input int v, input logic [15:0] eb,
                           input logic [31:0] es, input logic eo);
        int lat;
        convert(v, lat);
        chk({name, "_lat"}, 32'(lat), 32'd14);
        chk({name, "_bcd"}, 32'(bcd), 32'(eb));
        chk({name, "_ss"},  {ss3, ss2, ss1, ss0}, es);
        chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    endtask

    int lat;
    int dones;
    int vals [10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 10000, 16383};

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd",  32'(bcd),  32'd0);
        chk("rst_ss",   {ss3, ss2, ss1, ss0}, 32'h0000_003F);

        chk_lit("v1234",  1234,  16'h1234, 32'h065B4F66, 1'b0);
        chk_lit("v7",     7,     16'h0007, 32'h00000007, 1'b0);
        chk_lit("v0",     0,     16'h0000, 32'h0000003F, 1'b0);
        chk_lit("v9999",  9999,  16'h9999, 32'h6F6F6F6F, 1'b0);
        chk_lit("v10000", 10000, 16'h0000, 32'h40404040, 1'b1);
        chk_lit("v305",   305,   16'h0305, 32'h004F3F6D, 1'b0);

        // start while busy is ignored
        @(posedge clk);
        #2 value = 14'd42;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 value = 14'd5555;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        value = 14'd777;
        dones = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("ign_dones", 32'(dones), 32'd1);
        chk("ign_bcd",   32'(bcd),   32'h0042);

        // start held during the done cycle is accepted
        convert(42, lat);
        chk("hold_lat0", 32'(lat), 32'd14);
        value = 14'd5555;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done(lat);
        chk("hold_lat", 32'(lat), 32'd14);
        chk("hold_bcd", 32'(bcd), 32'h5555);

        // reset mid-conversion
        convert(42, lat);
        @(posedge clk);
        #2 value = 14'd1234;
        start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_bcd",  32'(bcd),  32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ss",   {ss3, ss2, ss1, ss0}, 32'h0000_003F);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        #1 reset = 1'b0;
        chk("abort_dones", 32'(dones), 32'd0);
        chk_lit("v88", 88, 16'h0088, 32'h00007F7F, 1'b0);

        // Random traffic: random values, starts during busy, occasional async reset
        for (int c = 0; c < 900; c++) begin
            @(posedge clk);
            #2;
            if ($urandom_range(0, 3) == 0) value = 14'(vals[$urandom_range(0, 9)]);
            else value = 14'($urandom_range(0, 16383));
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                #1 reset = 1'b0;
            end
        end
        start = 1'b0;
        repeat (20) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
